mood_state_engine: RTL and testbench



---
 rtl/moody_pkg.sv | 20 ++
 rtl/mood_channel.sv | 47 ++++
 rtl/mood_state_engine.sv | 169 ++++++++++++++++
 tb/tb_mood_state_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/moody_pkg.sv
// Shared encodings for the mood engine: physical states, 2-bit level classes
// and the fixed channel roles.
package moody_pkg;

  typedef enum logic [1:0] {
    AWAKE  = 2'b00,
    ASLEEP = 2'b01,
    DYING  = 2'b10,
    DEAD   = 2'b11
  } phys_state_e;

  localparam logic [1:0] CLS_LOW      = 2'b00;
  localparam logic [1:0] CLS_MODERATE = 2'b01;
  localparam logic [1:0] CLS_ELEVATED = 2'b10;
  localparam logic [1:0] CLS_HIGH     = 2'b11;

  localparam int CH_ENERGY = 0;
  localparam int CH_STRESS = 1;

endpackage

// File: rtl/mood_channel.sv
// One saturating drive channel: applies a signed -2..+2 delta per enabled
// step, or a single homeostatic step toward INIT when leak_en_i is set.
module mood_channel #(
  parameter int unsigned  W    = 7,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic signed [2:0] delta_i,
  input  logic              leak_en_i,
  output logic [W-1:0]      value_o
);

  logic [W-1:0] value_q, value_d;
  logic [W+1:0] sum;

  // Two guard bits: bit W+1 flags underflow below zero, bit W flags overflow.
  always_comb begin
    sum     = {2'b00, value_q} + {{(W-1){delta_i[2]}}, delta_i};
    value_d = value_q;
    if (leak_en_i) begin
      if (value_q > INIT) begin
        value_d = value_q - W'(1);
      end else if (value_q < INIT) begin
        value_d = value_q + W'(1);
      end
    end else if (sum[W+1]) begin
      value_d = '0;
    end else if (sum[W]) begin
      value_d = '1;
    end else begin
      value_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= INIT;
    end else if (en_i) begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/mood_state_engine.sv
// Drive channels plus physical-state FSM and heartbeat generator, all advancing
// only on clk edges qualified by tick_in.
module mood_state_engine
  import moody_pkg::*;
#(
  parameter int unsigned           N_CH        = 3,
  parameter int unsigned           W           = 7,
  parameter logic [N_CH*W-1:0]     INIT_VALS   = {7'd64, 7'd0, 7'd96},
  parameter int unsigned           LEAK_PERIOD = 8,
  parameter int unsigned           DYING_TICKS = 4,
  parameter int unsigned           HB_BASE     = 16,
  parameter int unsigned           HB_CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_in,
  input  logic [N_CH-1:0]     stim_inc,
  input  logic [N_CH-1:0]     stim_dec,
  output logic [N_CH*W-1:0]   level,
  output logic [N_CH*2-1:0]   level_cls,
  output logic [1:0]          state,
  output logic                heartbeat,
  output logic                dead
);

  localparam int unsigned LEAK_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int unsigned DY_W   = (DYING_TICKS > 1) ? $clog2(DYING_TICKS) : 1;

  phys_state_e         state_q, state_d;
  logic [LEAK_W-1:0]   leak_cnt_q, leak_cnt_d;
  logic [DY_W-1:0]     dying_cnt_q, dying_cnt_d;
  logic [HB_CNT_W-1:0] hb_cnt_q, hb_cnt_d, hb_period;
  logic                adv, leak_hit, state_change, hb_match;
  logic [W-1:0]        energy, stress;
  logic [1:0]          ecls, scls;
  logic signed [2:0]   fsm_delta [N_CH];
  logic [N_CH-1:0]     fsm_term;

  // DEAD freezes the whole model, so it is folded into the step enable.
  assign adv    = tick_in && (state_q != DEAD);
  assign energy = level[CH_ENERGY*W +: W];
  assign stress = level[CH_STRESS*W +: W];
  assign ecls   = energy[W-1 -: 2];
  assign scls   = stress[W-1 -: 2];

  assign leak_hit   = (leak_cnt_q == LEAK_W'(LEAK_PERIOD - 1));
  assign leak_cnt_d = leak_hit ? '0 : leak_cnt_q + LEAK_W'(1);

  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      fsm_delta[i] = '0;
    end
    fsm_term = '0;
    unique case (state_q)
      AWAKE: begin
        if (!stim_inc[CH_ENERGY]) begin
          fsm_delta[CH_ENERGY] = -3'sd1;
          fsm_term[CH_ENERGY]  = 1'b1;
        end
      end
      ASLEEP: begin
        fsm_delta[CH_ENERGY] = 3'sd1;
        fsm_delta[CH_STRESS] = -3'sd1;
        fsm_term[CH_ENERGY]  = 1'b1;
        fsm_term[CH_STRESS]  = 1'b1;
      end
      DYING: begin
        fsm_delta[CH_ENERGY] = -3'sd1;
        fsm_term[CH_ENERGY]  = 1'b1;
      end
      DEAD: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dying_cnt_d = dying_cnt_q;
    unique case (state_q)
      AWAKE: begin
        if (energy == '0) begin
          state_d = DYING;
        end else if (ecls == CLS_LOW && scls <= CLS_MODERATE) begin
          state_d = ASLEEP;
        end
      end
      ASLEEP: begin
        if (energy == '0) begin
          state_d = DYING;
        end else if (ecls == CLS_HIGH || scls == CLS_HIGH) begin
          state_d = AWAKE;
        end
      end
      DYING: begin
        if (energy != '0) begin
          state_d     = AWAKE;
          dying_cnt_d = '0;
        end else if (dying_cnt_q == DY_W'(DYING_TICKS - 1)) begin
          state_d = DEAD;
        end else begin
          dying_cnt_d = dying_cnt_q + DY_W'(1);
        end
      end
      DEAD: ;
    endcase
  end

  always_comb begin
    hb_period = HB_CNT_W'(4 * HB_BASE);
    unique case (state_q)
      AWAKE: begin
        hb_period = HB_CNT_W'(HB_BASE) >> scls;
        if (hb_period == '0) begin
          hb_period = HB_CNT_W'(1);
        end
      end
      ASLEEP:  hb_period = HB_CNT_W'(2 * HB_BASE);
      default: ;
    endcase
  end

  // >= also catches a count left above a period that just shrank with stress.
  assign hb_match     = (hb_cnt_q >= hb_period - HB_CNT_W'(1));
  assign state_change = adv && (state_d != state_q);
  assign hb_cnt_d     = (state_change || hb_match) ? '0 : hb_cnt_q + HB_CNT_W'(1);
  // Combinational so the beat lands exactly on the qualifying tick cycle.
  assign heartbeat    = adv && !rst && hb_match && !state_change;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= AWAKE;
      leak_cnt_q  <= '0;
      dying_cnt_q <= '0;
      hb_cnt_q    <= '0;
    end else if (adv) begin
      state_q     <= state_d;
      leak_cnt_q  <= leak_cnt_d;
      dying_cnt_q <= dying_cnt_d;
      hb_cnt_q    <= hb_cnt_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_ch
    logic signed [2:0] delta;
    logic              contrib;

    assign delta   = fsm_delta[gi] + $signed({2'b00, stim_inc[gi]})
                   - $signed({2'b00, stim_dec[gi]});
    assign contrib = stim_inc[gi] | stim_dec[gi] | fsm_term[gi];

    mood_channel #(
      .W    (W),
      .INIT (INIT_VALS[gi*W +: W])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (adv),
      .delta_i   (delta),
      .leak_en_i (leak_hit && !contrib),
      .value_o   (level[gi*W +: W])
    );

    assign level_cls[gi*2 +: 2] = level[gi*W + W - 2 +: 2];
  end

  assign state = state_q;
  assign dead  = (state_q == DEAD);

endmodule

// File: tb/tb_mood_state_engine.sv
// Directed bench for mood_state_engine at default parameters; expected values
// are hand-derived tick by tick from reset.
module tb_mood_state_engine;

  localparam int W = 7;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        tick_in  = 1'b0;
  logic [2:0]  stim_inc = '0;
  logic [2:0]  stim_dec = '0;
  logic [20:0] level;
  logic [5:0]  level_cls;
  logic [1:0]  state;
  logic        heartbeat;
  logic        dead;

  int   checks = 0;
  int   errors = 0;
  int   tick_n = 0;
  logic hb_seen = 1'b0;

  mood_state_engine dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .stim_inc  (stim_inc),
    .stim_dec  (stim_dec),
    .level     (level),
    .level_cls (level_cls),
    .state     (state),
    .heartbeat (heartbeat),
    .dead      (dead)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ch(input int i);
    return level[i*W +: W];
  endfunction

  // One clk cycle: drive, sample the combinational beat mid-cycle, then settle past the edge.
  task automatic step(input logic tk, input logic [2:0] inc, input logic [2:0] dec);
    tick_in  = tk;
    stim_inc = inc;
    stim_dec = dec;
    @(negedge clk);
    hb_seen = heartbeat;
    @(posedge clk);
    #1;
    if (tk) tick_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 3'b000, 3'b000);
    rst = 1'b0;
    tick_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 3'b111, 3'b000);
    rst = 1'b0;
    tick_n = 0;
    checks++; if (hb_seen !== 1'b0) begin errors++; $display("FAIL reset_heartbeat got %b want 0", hb_seen); end
    checks++; if (level !== {7'd64, 7'd0, 7'd96}) begin errors++; $display("FAIL reset_level got %h want %h", level, {7'd64, 7'd0, 7'd96}); end
    checks++; if (level_cls !== 6'b100011) begin errors++; $display("FAIL reset_cls got %b want 100011", level_cls); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL reset_dead got %b want 0", dead); end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_tick_gate();
    do_reset();
    repeat (3) step(1'b1, 3'b000, 3'b000);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 3'b111, 3'b000);
      checks++; if (hb_seen !== 1'b0) begin errors++; $display("FAIL gate_heartbeat cycle %0d got %b want 0", c, hb_seen); end
    end
    checks++; if (level !== {7'd64, 7'd0, 7'd93}) begin errors++; $display("FAIL gate_hold got %h want %h", level, {7'd64, 7'd0, 7'd93}); end
    step(1'b1, 3'b111, 3'b000);
    checks++; if (level !== {7'd65, 7'd1, 7'd94}) begin errors++; $display("FAIL gate_resume got %h want %h", level, {7'd65, 7'd1, 7'd94}); end
    $display("test_tick_gate done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_drift();
    do_reset();
    repeat (10) step(1'b1, 3'b000, 3'b000);
    checks++; if (level !== {7'd64, 7'd0, 7'd86}) begin errors++; $display("FAIL drift_level got %h want %h", level, {7'd64, 7'd0, 7'd86}); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL drift_state got %b want 00", state); end
    $display("test_drift done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_sleep_cycle();
    do_reset();
    for (int n = 1; n <= 133; n++) begin
      logic exp_hb;
      step(1'b1, 3'b000, 3'b000);
      exp_hb = ((n <= 64) && (n % 16 == 0)) || (n == 98) || (n == 130);
      checks++; if (hb_seen !== exp_hb) begin errors++; $display("FAIL sleep_heartbeat tick %0d got %b want %b", n, hb_seen, exp_hb); end
      if (n == 65) begin
        checks++; if (ch(0) !== 7'd31 || state !== 2'b00 || level_cls[1:0] !== 2'b00) begin errors++; $display("FAIL sleep_t65 energy %0d state %b cls %b want 31 00 00", ch(0), state, level_cls[1:0]); end
      end
      if (n == 66) begin
        checks++; if (ch(0) !== 7'd30 || state !== 2'b01) begin errors++; $display("FAIL sleep_t66 energy %0d state %b want 30 01", ch(0), state); end
      end
      if (n == 132) begin
        checks++; if (ch(0) !== 7'd96 || state !== 2'b01) begin errors++; $display("FAIL sleep_t132 energy %0d state %b want 96 01", ch(0), state); end
      end
      if (n == 133) begin
        checks++; if (level !== {7'd64, 7'd0, 7'd97} || state !== 2'b00) begin errors++; $display("FAIL sleep_wake level %h state %b want %h 00", level, state, {7'd64, 7'd0, 7'd97}); end
      end
    end
    $display("test_sleep_cycle done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_dead_and_reset();
    do_reset();
    repeat (64) step(1'b1, 3'b010, 3'b000);
    checks++; if (level !== {7'd64, 7'd64, 7'd32} || state !== 2'b00) begin errors++; $display("FAIL stress_ramp level %h state %b want %h 00", level, state, {7'd64, 7'd64, 7'd32}); end
    repeat (16) step(1'b1, 3'b010, 3'b001);
    checks++; if (level !== {7'd64, 7'd80, 7'd0} || state !== 2'b00) begin errors++; $display("FAIL energy_zero level %h state %b want %h 00", level, state, {7'd64, 7'd80, 7'd0}); end
    for (int n = 81; n <= 85; n++) begin
      logic [1:0] exp_st;
      logic [6:0] exp_stress;
      step(1'b1, 3'b010, 3'b001);
      exp_st     = (n == 85) ? 2'b11 : 2'b10;
      exp_stress = 7'(n);
      checks++; if (state !== exp_st || ch(0) !== 7'd0 || ch(1) !== exp_stress) begin errors++; $display("FAIL dying tick %0d state %b energy %0d stress %0d want %b 0 %0d", n, state, ch(0), ch(1), exp_st, exp_stress); end
    end
    checks++; if (dead !== 1'b1) begin errors++; $display("FAIL dead_flag got %b want 1", dead); end
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 3'b111, 3'b000);
      checks++; if (level !== {7'd64, 7'd85, 7'd0} || hb_seen !== 1'b0 || state !== 2'b11) begin errors++; $display("FAIL dead_frozen step %0d level %h hb %b state %b want %h 0 11", n, level, hb_seen, state, {7'd64, 7'd85, 7'd0}); end
    end
    rst = 1'b1;
    step(1'b1, 3'b111, 3'b000);
    rst = 1'b0;
    tick_n = 0;
    checks++; if (state !== 2'b00 || dead !== 1'b0) begin errors++; $display("FAIL dead_rst_state state %b dead %b want 00 0", state, dead); end
    checks++; if (level !== {7'd64, 7'd0, 7'd96}) begin errors++; $display("FAIL dead_rst_level got %h want %h", level, {7'd64, 7'd0, 7'd96}); end
    $display("test_dead_and_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_leak();
    do_reset();
    for (int n = 1; n <= 80; n++) begin
      logic [2:0] inc;
      logic [2:0] dec;
      int         exp_c2;
      inc = ((n <= 6) || (n == 8)) ? 3'b100 : 3'b000;
      dec = ((n == 8) || (n == 65) || (n == 66)) ? 3'b100 : 3'b000;
      step(1'b1, inc, dec);
      if (n <= 64) exp_c2 = (n == 7) ? 70 : ((70 - (n / 8 - 1)) < 64 ? 64 : 70 - (n / 8 - 1));
      else if (n == 65) exp_c2 = 63;
      else if (n < 72) exp_c2 = 62;
      else if (n < 80) exp_c2 = 63;
      else exp_c2 = 64;
      if (n >= 7) begin
        checks++; if (ch(2) !== 7'(exp_c2)) begin errors++; $display("FAIL leak_ch2 tick %0d got %0d want %0d", n, ch(2), exp_c2); end
      end
    end
    $display("test_leak done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      step(1'b1, 3'b001, 3'b010);
      if (n == 30 || n == 31 || n == 40) begin
        logic [6:0] exp_e;
        exp_e = (n == 30) ? 7'd126 : 7'd127;
        checks++; if (ch(0) !== exp_e || ch(1) !== 7'd0 || state !== 2'b00) begin errors++; $display("FAIL saturate tick %0d energy %0d stress %0d state %b want %0d 0 00", n, ch(0), ch(1), state, exp_e); end
      end
    end
    $display("test_saturation done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_heartbeat();
    do_reset();
    for (int n = 1; n <= 80; n++) begin
      logic exp_hb;
      step(1'b1, 3'b010, 3'b000);
      exp_hb = ((n <= 32) && (n % 16 == 0)) || ((n > 32) && (n <= 64) && (n % 8 == 0))
             || ((n > 64) && (n % 4 == 0));
      checks++; if (hb_seen !== exp_hb) begin errors++; $display("FAIL hb_rate tick %0d got %b want %b", n, hb_seen, exp_hb); end
    end
    for (int c = 1; c <= 16; c++) begin
      logic exp_hb;
      step((c % 2) == 0, 3'b010, 3'b000);
      exp_hb = (c == 8) || (c == 16);
      checks++; if (hb_seen !== exp_hb) begin errors++; $display("FAIL hb_half_rate cycle %0d got %b want %b", c, hb_seen, exp_hb); end
    end
    checks++; if (state !== 2'b00 || ch(0) !== 7'd8) begin errors++; $display("FAIL hb_end state %b energy %0d want 00 8", state, ch(0)); end
    $display("test_heartbeat done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_tick_gate();
    test_drift();
    test_sleep_cycle();
    test_dead_and_reset();
    test_leak();
    test_saturation();
    test_heartbeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
